cpu_controller: RTL and testbench

//  Fetch/decode/sequence FSM driving the 16-bit register-file/ALU datapath. Holds PC, IR and data-address register.

---
 rtl/cpu_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit register-file/ALU datapath.
// Control outputs are registered: each one is decoded from the state about to be entered.
module cpu_controller #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     read_data,
  input  logic [15:0]     datapath_out,
  output logic [1:0]      mem_cmd,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     sximm5,
  output logic [15:0]     sximm8,
  output logic [3:0]      vsel,
  output logic            asel,
  output logic            bsel,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic [1:0]      ALUop,
  output logic [1:0]      shift,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic            write,
  output logic            halted
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GA, S_GB, S_ALU, S_WR, S_WI,
    S_AD, S_LA, S_MR1, S_MR2, S_SB, S_PB, S_MW, S_HALT
  } state_t;

  state_t          state_reg, state_next;
  logic [15:0]     ir_reg;
  logic [PC_W-1:0] pc_reg, addr_reg;

  logic [2:0] op, rn, rd, rm;
  logic [1:0] sub, sh;
  logic       is_movi, is_movr, is_mvn, is_add, is_cmp, is_and, is_ldr, is_str;

  assign op  = ir_reg[15:13];
  assign sub = ir_reg[12:11];
  assign rn  = ir_reg[10:8];
  assign rd  = ir_reg[7:5];
  assign sh  = ir_reg[4:3];
  assign rm  = ir_reg[2:0];

  assign is_movi = ({op, sub} == 5'b110_10);
  assign is_movr = ({op, sub} == 5'b110_00);
  assign is_add  = ({op, sub} == 5'b101_00);
  assign is_cmp  = ({op, sub} == 5'b101_01);
  assign is_and  = ({op, sub} == 5'b101_10);
  assign is_mvn  = ({op, sub} == 5'b101_11);
  assign is_ldr  = ({op, sub} == 5'b011_00);
  assign is_str  = ({op, sub} == 5'b100_00);

  assign sximm5[4:0] = ir_reg[4:0];
  assign sximm8[7:0] = ir_reg[7:0];
  for (genvar gi = 5; gi < 16; gi++) begin : g_sx5
    assign sximm5[gi] = ir_reg[4];
  end
  for (genvar gi = 8; gi < 16; gi++) begin : g_sx8
    assign sximm8[gi] = ir_reg[7];
  end

  assign pc       = pc_reg;
  assign mem_addr = (state_reg inside {S_MR1, S_MR2, S_MW}) ? addr_reg : pc_reg;

  // Only the low PC_W bits of C form an address; the rest is store data for the datapath.
  logic unused_bits;
  assign unused_bits = ^datapath_out[15:PC_W];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:  state_next = S_IF1;
      S_IF1:  state_next = S_IF2;
      S_IF2:  state_next = S_UPC;
      S_UPC:  state_next = S_DEC;
      S_DEC: begin
        if (is_movi)                                         state_next = S_WI;
        else if (is_movr || is_mvn)                          state_next = S_GB;
        else if (is_add || is_cmp || is_and || is_ldr || is_str) state_next = S_GA;
        else                                                 state_next = S_HALT;
      end
      S_GA:   state_next = (is_ldr || is_str) ? S_AD : S_GB;
      S_GB:   state_next = S_ALU;
      S_ALU:  state_next = is_cmp ? S_IF1 : S_WR;
      S_AD:   state_next = S_LA;
      S_LA:   state_next = is_ldr ? S_MR1 : S_SB;
      S_MR1:  state_next = S_MR2;
      S_SB:   state_next = S_PB;
      S_PB:   state_next = S_MW;
      S_WR, S_WI, S_MR2, S_MW: state_next = S_IF1;
      default: state_next = S_HALT;
    endcase
  end

  logic [1:0] mem_cmd_next, alu_op_next, shift_next;
  logic [3:0] vsel_next;
  logic [2:0] readnum_next, writenum_next;
  logic       asel_next, bsel_next, loada_next, loadb_next, loadc_next, loads_next;
  logic       write_next, halted_next;

  always_comb begin
    mem_cmd_next  = CMD_NONE;
    vsel_next     = 4'b1000;
    asel_next     = 1'b0;
    bsel_next     = 1'b0;
    loada_next    = 1'b0;
    loadb_next    = 1'b0;
    loadc_next    = 1'b0;
    loads_next    = 1'b0;
    alu_op_next   = 2'b00;
    shift_next    = 2'b00;
    readnum_next  = 3'd0;
    writenum_next = 3'd0;
    write_next    = 1'b0;
    halted_next   = 1'b0;
    case (state_next)
      S_IF1, S_IF2, S_MR1: mem_cmd_next = CMD_READ;
      S_GA: begin
        readnum_next = rn;
        loada_next   = 1'b1;
      end
      S_GB: begin
        readnum_next = rm;
        loadb_next   = 1'b1;
        shift_next   = sh;
      end
      S_ALU: begin
        // MOVr passes B through as 0 + B; CMP only updates status flags.
        asel_next   = is_movr;
        alu_op_next = is_movr ? 2'b00 : sub;
        loadc_next  = ~is_cmp;
        loads_next  = is_cmp;
      end
      S_WR: begin
        writenum_next = rd;
        write_next    = 1'b1;
      end
      S_WI: begin
        vsel_next     = 4'b0010;
        writenum_next = rn;
        write_next    = 1'b1;
      end
      S_AD: begin
        bsel_next  = 1'b1;
        loadc_next = 1'b1;
      end
      S_MR2: begin
        mem_cmd_next  = CMD_READ;
        vsel_next     = 4'b0001;
        writenum_next = rd;
        write_next    = 1'b1;
      end
      S_SB: begin
        readnum_next = rd;
        loadb_next   = 1'b1;
      end
      S_PB: begin
        asel_next  = 1'b1;
        loadc_next = 1'b1;
      end
      S_MW:   mem_cmd_next = CMD_WRITE;
      S_HALT: halted_next  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_RST;
      ir_reg    <= '0;
      addr_reg  <= '0;
      pc_reg    <= START_PC;
      mem_cmd   <= CMD_NONE;
      vsel      <= 4'b1000;
      asel      <= 1'b0;
      bsel      <= 1'b0;
      loada     <= 1'b0;
      loadb     <= 1'b0;
      loadc     <= 1'b0;
      loads     <= 1'b0;
      ALUop     <= 2'b00;
      shift     <= 2'b00;
      readnum   <= 3'd0;
      writenum  <= 3'd0;
      write     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IF2) ir_reg <= read_data;
      if (state_reg == S_UPC) pc_reg <= pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
      if (state_reg == S_LA)  addr_reg <= datapath_out[PC_W-1:0];
      mem_cmd  <= mem_cmd_next;
      vsel     <= vsel_next;
      asel     <= asel_next;
      bsel     <= bsel_next;
      loada    <= loada_next;
      loadb    <= loadb_next;
      loadc    <= loadc_next;
      loads    <= loads_next;
      ALUop    <= alu_op_next;
      shift    <= shift_next;
      readnum  <= readnum_next;
      writenum <= writenum_next;
      write    <= write_next;
      halted   <= halted_next;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: a cycle-stamped table of expected controls over a small
// program, plus hand sequences for reset abort, illegal opcode and PC wrap.
module tb_cpu_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] read_data, datapath_out;
  logic [1:0]  mem_cmd, alu_op, shift;
  logic [8:0]  mem_addr, pc;
  logic [15:0] sximm5, sximm8;
  logic [3:0]  vsel;
  logic        asel, bsel, loada, loadb, loadc, loads, write, halted;
  logic [2:0]  readnum, writenum;

  logic [15:0] read_data_w;
  logic [1:0]  mem_cmd_w, alu_op_w, shift_w;
  logic [8:0]  mem_addr_w, pc_w;
  logic [15:0] sximm5_w, sximm8_w;
  logic [3:0]  vsel_w;
  logic        asel_w, bsel_w, loada_w, loadb_w, loadc_w, loads_w, write_w, halted_w;
  logic [2:0]  readnum_w, writenum_w;

  logic [15:0] mem [512];
  assign read_data   = mem[mem_addr];
  assign read_data_w = mem[mem_addr_w];

  cpu_controller #(.PC_W(9), .START_PC(9'd0)) dut (
    .clk(clk), .reset(reset), .read_data(read_data), .datapath_out(datapath_out),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .pc(pc), .sximm5(sximm5), .sximm8(sximm8),
    .vsel(vsel), .asel(asel), .bsel(bsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .ALUop(alu_op), .shift(shift), .readnum(readnum), .writenum(writenum),
    .write(write), .halted(halted)
  );

  cpu_controller #(.PC_W(9), .START_PC(9'd511)) dut_wrap (
    .clk(clk), .reset(reset), .read_data(read_data_w), .datapath_out(datapath_out),
    .mem_cmd(mem_cmd_w), .mem_addr(mem_addr_w), .pc(pc_w), .sximm5(sximm5_w), .sximm8(sximm8_w),
    .vsel(vsel_w), .asel(asel_w), .bsel(bsel_w), .loada(loada_w), .loadb(loadb_w), .loadc(loadc_w),
    .loads(loads_w), .ALUop(alu_op_w), .shift(shift_w), .readnum(readnum_w), .writenum(writenum_w),
    .write(write_w), .halted(halted_w)
  );

  typedef struct packed {
    logic [1:0] mem_cmd;
    logic [3:0] vsel;
    logic [5:0] en;        // asel, bsel, loada, loadb, loadc, loads
    logic [1:0] alu_op;
    logic [1:0] shift;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       halted;
  } ctl_t;

  typedef struct {
    int          cyc;
    logic [15:0] dp;
    ctl_t        ctl;
    logic [8:0]  ma;
    logic [8:0]  pcv;
    int          sxs;      // 0 none, 1 sximm8, 2 sximm5
    logic [15:0] sx;
  } row_t;

  localparam logic [3:0] VC = 4'b1000, VI = 4'b0010, VM = 4'b0001;
  localparam ctl_t DEF_CTL  = {2'b00, 4'b1000, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0};
  localparam ctl_t HALT_CTL = {2'b00, 4'b1000, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  row_t tbl[$];

  function automatic row_t r(input int c, input logic [15:0] dp, input logic [1:0] mc,
                             input logic [8:0] ma, input logic [8:0] pcv, input logic [3:0] vs,
                             input logic [5:0] en, input logic [1:0] op, input logic [1:0] sh,
                             input logic [2:0] rn, input logic [2:0] wn, input logic wr,
                             input logic hl, input int sxs, input logic [15:0] sx);
    row_t x;
    x.cyc = c; x.dp = dp; x.ma = ma; x.pcv = pcv; x.sxs = sxs; x.sx = sx;
    x.ctl = {mc, vs, en, op, sh, rn, wn, wr, hl};
    return x;
  endfunction

  function automatic ctl_t cur();
    return {mem_cmd, vsel, asel, bsel, loada, loadb, loadc, loads, alu_op, shift,
            readnum, writenum, write, halted};
  endfunction

  task automatic check(input string what, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  // A register write and a memory write must never coincide.
  always @(negedge clk) begin
    n_checks++;
    if (write === 1'b1 && mem_cmd === 2'b10) begin
      n_fail++;
      $display("FAIL write_vs_memwrite: write=%b mem_cmd=%b at cycle %0d", write, mem_cmd, cyc);
    end
  end

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 16'h0000;
    mem[0] = 16'hD007;  // MOVi R0,#7
    mem[1] = 16'hD1FE;  // MOVi R1,#-2
    mem[2] = 16'hA148;  // ADD  R2,R1,R0,LSL#1
    mem[3] = 16'h6061;  // LDR  R3,[R0,#1]
    mem[4] = 16'h8060;  // STR  R3,[R0,#0]
    mem[5] = 16'hA900;  // CMP  R1,R0
    mem[6] = 16'hB891;  // MVN  R4,R1,LSR#1
    mem[7] = 16'hC0BA;  // MOVr R5,R2,ASR#1
    mem[8] = 16'hB1C0;  // AND  R6,R1,R0
    mem[9] = 16'hE000;  // HALT
    mem[511] = 16'hD007;
    datapath_out = 16'h0008;

    //                cyc dp        mc     ma      pc     vsel en        op     sh     rn    wn    wr hl sxs sx
    tbl.push_back(r(  0, 16'h0008, 2'b00, 9'd0,   9'd0,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r(  1, 16'h0008, 2'b01, 9'd0,   9'd0,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r(  2, 16'h0008, 2'b01, 9'd0,   9'd0,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r(  3, 16'h0008, 2'b00, 9'd0,   9'd0,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r(  4, 16'h0008, 2'b00, 9'd0,   9'd1,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r(  5, 16'h0008, 2'b00, 9'd0,   9'd1,  VI, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 1, 0, 1, 16'h0007));
    tbl.push_back(r(  6, 16'h0008, 2'b01, 9'd1,   9'd1,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 10, 16'h0008, 2'b00, 9'd0,   9'd2,  VI, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd1, 1, 0, 1, 16'hFFFE));
    tbl.push_back(r( 11, 16'h0008, 2'b01, 9'd2,   9'd2,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 15, 16'h0008, 2'b00, 9'd0,   9'd3,  VC, 6'b001000, 2'b00, 2'b00, 3'd1, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 16, 16'h0008, 2'b00, 9'd0,   9'd3,  VC, 6'b000100, 2'b00, 2'b01, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 17, 16'h0008, 2'b00, 9'd0,   9'd3,  VC, 6'b000010, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 18, 16'h0008, 2'b00, 9'd0,   9'd3,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd2, 1, 0, 0, 16'h0000));
    tbl.push_back(r( 19, 16'h0008, 2'b01, 9'd3,   9'd3,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 23, 16'h0008, 2'b00, 9'd0,   9'd4,  VC, 6'b001000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 24, 16'h0008, 2'b00, 9'd0,   9'd4,  VC, 6'b010010, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 2, 16'h0001));
    tbl.push_back(r( 25, 16'h0008, 2'b00, 9'd0,   9'd4,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 26, 16'h0008, 2'b01, 9'd8,   9'd4,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 27, 16'h0008, 2'b01, 9'd8,   9'd4,  VM, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd3, 1, 0, 0, 16'h0000));
    tbl.push_back(r( 28, 16'h0008, 2'b01, 9'd4,   9'd4,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 32, 16'h0008, 2'b00, 9'd0,   9'd5,  VC, 6'b001000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 33, 16'h0008, 2'b00, 9'd0,   9'd5,  VC, 6'b010010, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 34, 16'h0008, 2'b00, 9'd0,   9'd5,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 35, 16'h1234, 2'b00, 9'd0,   9'd5,  VC, 6'b000100, 2'b00, 2'b00, 3'd3, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 36, 16'h1234, 2'b00, 9'd0,   9'd5,  VC, 6'b100010, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 37, 16'h1234, 2'b10, 9'h034, 9'd5,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 38, 16'h0008, 2'b01, 9'd5,   9'd5,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 42, 16'h0008, 2'b00, 9'd0,   9'd6,  VC, 6'b001000, 2'b00, 2'b00, 3'd1, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 43, 16'h0008, 2'b00, 9'd0,   9'd6,  VC, 6'b000100, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 44, 16'h0008, 2'b00, 9'd0,   9'd6,  VC, 6'b000001, 2'b01, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 45, 16'h0008, 2'b01, 9'd6,   9'd6,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 49, 16'h0008, 2'b00, 9'd0,   9'd7,  VC, 6'b000100, 2'b00, 2'b10, 3'd1, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 50, 16'h0008, 2'b00, 9'd0,   9'd7,  VC, 6'b000010, 2'b11, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 51, 16'h0008, 2'b00, 9'd0,   9'd7,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd4, 1, 0, 0, 16'h0000));
    tbl.push_back(r( 52, 16'h0008, 2'b01, 9'd7,   9'd7,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 56, 16'h0008, 2'b00, 9'd0,   9'd8,  VC, 6'b000100, 2'b00, 2'b11, 3'd2, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 57, 16'h0008, 2'b00, 9'd0,   9'd8,  VC, 6'b100010, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 58, 16'h0008, 2'b00, 9'd0,   9'd8,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd5, 1, 0, 0, 16'h0000));
    tbl.push_back(r( 59, 16'h0008, 2'b01, 9'd8,   9'd8,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 63, 16'h0008, 2'b00, 9'd0,   9'd9,  VC, 6'b001000, 2'b00, 2'b00, 3'd1, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 64, 16'h0008, 2'b00, 9'd0,   9'd9,  VC, 6'b000100, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 65, 16'h0008, 2'b00, 9'd0,   9'd9,  VC, 6'b000010, 2'b10, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 66, 16'h0008, 2'b00, 9'd0,   9'd9,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd6, 1, 0, 0, 16'h0000));
    tbl.push_back(r( 67, 16'h0008, 2'b01, 9'd9,   9'd9,  VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 0, 0, 16'h0000));
    tbl.push_back(r( 71, 16'h0008, 2'b00, 9'd0,   9'd10, VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 1, 0, 16'h0000));
    tbl.push_back(r( 91, 16'h0008, 2'b00, 9'd0,   9'd10, VC, 6'b000000, 2'b00, 2'b00, 3'd0, 3'd0, 0, 1, 0, 16'h0000));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      datapath_out = tbl[i].dp;
      while (cyc < tbl[i].cyc) tick();
      check($sformatf("ctl@%0d", cyc), cur(), tbl[i].ctl);
      check($sformatf("pc@%0d", cyc), {15'd0, pc}, {15'd0, tbl[i].pcv});
      if (tbl[i].ctl.mem_cmd != 2'b00)
        check($sformatf("mem_addr@%0d", cyc), {15'd0, mem_addr}, {15'd0, tbl[i].ma});
      if (tbl[i].sxs == 1) check($sformatf("sximm8@%0d", cyc), {8'd0, sximm8}, {8'd0, tbl[i].sx});
      if (tbl[i].sxs == 2) check($sformatf("sximm5@%0d", cyc), {8'd0, sximm5}, {8'd0, tbl[i].sx});
      if (cyc == 1) check("wrap_fetch_addr", {15'd0, mem_addr_w}, 24'd511);
      if (cyc == 3) check("wrap_pc_upc", {15'd0, pc_w}, 24'd511);
      if (cyc == 4) check("wrap_pc_after", {15'd0, pc_w}, 24'd0);
      $display("cyc %0d: ctl=%h pc=%0d mem_addr=%0d", cyc, cur(), pc, mem_addr);
    end

    // Reset during GB of an ADD: the WR must never happen.
    mem[0] = 16'hA148;
    do_reset();
    while (cyc < 6) tick();
    check("abort_gb", {18'd0, readnum, loadb, shift}, {18'd0, 3'd0, 1'b1, 2'b01});
    reset = 1'b1;
    tick();
    check("abort_ctl", cur(), DEF_CTL);
    check("abort_pc", {15'd0, pc}, 24'd0);
    tick();
    check("abort_hold", cur(), DEF_CTL);
    reset = 1'b0;
    tick();
    check("abort_refetch", {22'd0, mem_cmd}, 24'd1);
    check("abort_refetch_wr", {23'd0, write}, 24'd0);
    $display("abort sequence: ctl=%h pc=%0d", cur(), pc);

    // Undefined encoding (110_11) must decode straight to HALT.
    mem[0] = 16'hD800;
    do_reset();
    while (cyc < 4) tick();
    check("illegal_dec", {23'd0, halted}, 24'd0);
    tick();
    check("illegal_halt", cur(), HALT_CTL);
    check("illegal_pc", {15'd0, pc}, 24'd1);
    $display("illegal opcode: ctl=%h pc=%0d", cur(), pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
